clause_loader: RTL and testbench

Upstream front end of the SAT solver. It accepts the serial clause stream on `load`/`i`, where each clause is two consecutive words: first the positive-literal mask, then the negative-literal mask. It pairs the words into clauses and discards padding and tautologies. Surviving clauses go into an internal clause buffer, which the solver core reads through a registered random-access port once `ready` is raised.

---
 rtl/common.sv | 14 +
 rtl/clause_ram.sv | 29 ++
 rtl/clause_loader.sv | 138 +++++++++++++
 tb/tb_clause_loader.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/common.sv
// Shared types and default sizes for the clause loading front end.
package common;

  localparam int number_literal = 5;
  localparam int max_clause     = 16;

  typedef struct packed {
    logic [number_literal-1:0] pos;
    logic [number_literal-1:0] neg;
  } clause_t;

  typedef enum logic [1:0] {IDLE, POS, NEG, DONE} load_state_t;

endpackage

// File: rtl/clause_ram.sv
// Clause buffer: synchronous write, registered read, no reset on the array so it maps to block RAM.
module clause_ram
  import common::*;
#(
  parameter int WIDTH = 2 * number_literal,
  parameter int DEPTH = max_clause,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_reg;

  always_ff @(posedge clock) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data_reg <= mem[rd_addr];
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/clause_loader.sv
// Pairs the serial pos/neg word stream into clauses, drops padding and tautologies,
// stores survivors in the clause buffer and exposes it through a registered read port.
module clause_loader
  import common::*;
#(
  parameter int NUM_LIT     = number_literal,
  parameter int MAX_CLAUSES = max_clause,
  localparam int AW         = $clog2(MAX_CLAUSES),
  localparam int CW         = AW + 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic [NUM_LIT-1:0] i,
  input  logic [AW-1:0]      rd_addr,
  output logic [NUM_LIT-1:0] rd_pos,
  output logic [NUM_LIT-1:0] rd_neg,
  output logic [CW-1:0]      clause_count,
  output logic               ready,
  output logic               overflow,
  output logic               odd_error
);

  load_state_t          state_reg, state_next;
  logic [NUM_LIT-1:0]   pend_pos_reg, pend_pos_next;
  logic [CW-1:0]        count_reg, count_next;
  logic                 ready_reg, ready_next;
  logic                 overflow_reg, overflow_next;
  logic                 odd_error_reg, odd_error_next;
  logic                 rd_valid_reg;
  logic                 wr_en;
  logic [NUM_LIT-1:0]   overlap;
  logic                 is_padding;
  logic                 is_tautology;
  logic                 buf_full;
  logic [2*NUM_LIT-1:0] rd_word;

  // Classifier works on the pending pos word and the neg word currently on the bus.
  for (genvar gi = 0; gi < NUM_LIT; gi++) begin : g_overlap
    assign overlap[gi] = pend_pos_reg[gi] & i[gi];
  end

  assign is_padding   = (pend_pos_reg == '0) && (i == '0);
  assign is_tautology = |overlap;
  assign buf_full     = (count_reg >= CW'(MAX_CLAUSES));

  always_comb begin
    state_next     = state_reg;
    pend_pos_next  = pend_pos_reg;
    count_next     = count_reg;
    ready_next     = ready_reg;
    overflow_next  = overflow_reg;
    odd_error_next = odd_error_reg;
    wr_en          = 1'b0;

    unique case (state_reg)
      IDLE, DONE: begin
        if (load) begin
          count_next     = '0;
          ready_next     = 1'b0;
          overflow_next  = 1'b0;
          odd_error_next = 1'b0;
          pend_pos_next  = i;
          state_next     = NEG;
        end
      end
      POS: begin
        if (load) begin
          pend_pos_next = i;
          state_next    = NEG;
        end else begin
          ready_next = 1'b1;
          state_next = DONE;
        end
      end
      NEG: begin
        if (load) begin
          state_next = POS;
          if (!is_padding && !is_tautology) begin
            if (!buf_full) begin
              wr_en      = 1'b1;
              count_next = count_reg + CW'(1);
            end else begin
              overflow_next = 1'b1;
            end
          end
        end else begin
          // Stream ended between a pos word and its neg word: the half clause is dropped.
          odd_error_next = 1'b1;
          ready_next     = 1'b1;
          state_next     = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      pend_pos_reg  <= '0;
      count_reg     <= '0;
      ready_reg     <= 1'b0;
      overflow_reg  <= 1'b0;
      odd_error_reg <= 1'b0;
      rd_valid_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pend_pos_reg  <= pend_pos_next;
      count_reg     <= count_next;
      ready_reg     <= ready_next;
      overflow_reg  <= overflow_next;
      odd_error_reg <= odd_error_next;
      // Masking bit travels alongside the RAM read so stale entries read as zero.
      rd_valid_reg  <= ({1'b0, rd_addr} < count_reg);
    end
  end

  clause_ram #(
    .WIDTH(2 * NUM_LIT),
    .DEPTH(MAX_CLAUSES)
  ) u_clause_ram (
    .clock  (clock),
    .we     (wr_en && !reset),
    .wr_addr(count_reg[AW-1:0]),
    .wr_data({pend_pos_reg, i}),
    .rd_addr(rd_addr),
    .rd_data(rd_word)
  );

  assign rd_pos       = rd_valid_reg ? rd_word[2*NUM_LIT-1:NUM_LIT] : '0;
  assign rd_neg       = rd_valid_reg ? rd_word[NUM_LIT-1:0] : '0;
  assign clause_count = count_reg;
  assign ready        = ready_reg;
  assign overflow     = overflow_reg;
  assign odd_error    = odd_error_reg;

endmodule

// File: tb/tb_clause_loader.sv
// Directed bench for clause_loader: a default-size instance and a 4-deep instance share one stream.
module tb_clause_loader;
  import common::*;

  typedef struct {
    logic [4:0] pos;
    logic [4:0] neg;
    int         exp_count;
    int         exp_count_s;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       load;
  logic [4:0] i;
  logic [3:0] rd_addr;
  logic [1:0] rd_addr_s;
  logic [4:0] rd_pos, rd_neg, rd_pos_s, rd_neg_s;
  logic [4:0] clause_count;
  logic [2:0] clause_count_s;
  logic       ready, overflow, odd_error;
  logic       ready_s, overflow_s, odd_error_s;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  clause_loader dut (
    .clock(clock), .reset(reset), .load(load), .i(i), .rd_addr(rd_addr),
    .rd_pos(rd_pos), .rd_neg(rd_neg), .clause_count(clause_count),
    .ready(ready), .overflow(overflow), .odd_error(odd_error)
  );

  clause_loader #(.NUM_LIT(5), .MAX_CLAUSES(4)) dut_s (
    .clock(clock), .reset(reset), .load(load), .i(i), .rd_addr(rd_addr_s),
    .rd_pos(rd_pos_s), .rd_neg(rd_neg_s), .clause_count(clause_count_s),
    .ready(ready_s), .overflow(overflow_s), .odd_error(odd_error_s)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic word(input logic [4:0] w);
    load = 1'b1;
    i    = w;
    cyc();
  endtask

  task automatic pair(input logic [4:0] p, input logic [4:0] n);
    word(p);
    word(n);
  endtask

  task automatic end_stream();
    load = 1'b0;
    i    = '0;
    cyc();
  endtask

  task automatic read_chk(input string name, input int a, input logic [4:0] ep, input logic [4:0] en);
    rd_addr = 4'(a);
    cyc();
    chk({name, "_pos"}, rd_pos, ep);
    chk({name, "_neg"}, rd_neg, en);
  endtask

  vec_t       stream1 [10];
  logic [4:0] exp_pos [16];
  logic [4:0] exp_neg [16];

  initial begin
    stream1[0] = '{5'b11100, 5'b00000, 1, 1};
    stream1[1] = '{5'b00000, 5'b11100, 2, 2};
    stream1[2] = '{5'b00001, 5'b00010, 3, 3};
    stream1[3] = '{5'b00010, 5'b10000, 4, 4};
    stream1[4] = '{5'b01100, 5'b00000, 5, 4};
    stream1[5] = '{5'b11011, 5'b00100, 6, 4};
    stream1[6] = '{5'b01010, 5'b00001, 7, 4};
    stream1[7] = '{5'b00000, 5'b00000, 7, 4};
    stream1[8] = '{5'b00000, 5'b00000, 7, 4};
    stream1[9] = '{5'b00000, 5'b00000, 7, 4};
    for (int k = 0; k < 16; k++) begin
      exp_pos[k] = '0;
      exp_neg[k] = '0;
    end
    for (int k = 0; k < 7; k++) begin
      exp_pos[k] = stream1[k].pos;
      exp_neg[k] = stream1[k].neg;
    end

    reset = 1'b1; load = 1'b0; i = '0; rd_addr = '0; rd_addr_s = '0;
    repeat (3) cyc();
    chk("rst_count", clause_count, 0);
    chk("rst_ready", ready, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_odd", odd_error, 0);
    chk("rst_rd_pos", rd_pos, 0);
    chk("rst_rd_neg", rd_neg, 0);
    chk("rst_count_s", clause_count_s, 0);
    reset = 1'b0;
    cyc();

    // Main stream: 7 clauses then 3 padding pairs
    for (int k = 0; k < 10; k++) begin
      word(stream1[k].pos);
      if (k == 0) chk("s1_ready_low", ready, 0);
      word(stream1[k].neg);
      chk($sformatf("s1_count_%0d", k), clause_count, stream1[k].exp_count);
      chk($sformatf("s1_count_s_%0d", k), clause_count_s, stream1[k].exp_count_s);
    end
    chk("s1_ready_before_end", ready, 0);
    end_stream();
    chk("s1_ready", ready, 1);
    chk("s1_count", clause_count, 7);
    chk("s1_overflow", overflow, 0);
    chk("s1_odd", odd_error, 0);
    chk("s1_overflow_s", overflow_s, 1);
    for (int k = 0; k < 16; k++) begin
      read_chk($sformatf("s1_rd%0d", k), k, exp_pos[k], exp_neg[k]);
    end
    chk("s1_ready_held", ready, 1);

    // Read latency: new address only shows after the next edge
    rd_addr = 4'd2;
    cyc();
    rd_addr = 4'd9;
    #1;
    chk("lat_old_pos", rd_pos, 5'b00001);
    cyc();
    chk("lat_new_pos", rd_pos, 5'b00000);

    // Tautology between two valid clauses
    word(5'b11000);
    chk("t_ready_drop", ready, 0);
    chk("t_count_clear", clause_count, 0);
    chk("t_overflow_s_clear", overflow_s, 0);
    word(5'b00100);
    pair(5'b10000, 5'b10010);
    chk("t_taut_not_counted", clause_count, 1);
    pair(5'b00011, 5'b01000);
    end_stream();
    chk("t_count", clause_count, 2);
    chk("t_ready", ready, 1);
    read_chk("t_rd1", 1, 5'b00011, 5'b01000);
    read_chk("t_rd2", 2, 5'b00000, 5'b00000);

    // Overflow on the 4-deep instance
    pair(5'b10000, 5'b00001);
    pair(5'b01000, 5'b00010);
    pair(5'b00100, 5'b00001);
    pair(5'b00010, 5'b01000);
    chk("o_count_s_full", clause_count_s, 4);
    chk("o_overflow_s_pre", overflow_s, 0);
    pair(5'b00001, 5'b10000);
    chk("o_overflow_s_rise", overflow_s, 1);
    pair(5'b11000, 5'b00011);
    end_stream();
    chk("o_count_s", clause_count_s, 4);
    chk("o_overflow_s", overflow_s, 1);
    chk("o_count", clause_count, 6);
    chk("o_overflow", overflow, 0);
    rd_addr_s = 2'd3;
    cyc();
    chk("o_rd3_pos", rd_pos_s, 5'b00010);
    chk("o_rd3_neg", rd_neg_s, 5'b01000);
    rd_addr_s = 2'd0;
    cyc();
    chk("o_rd0_pos", rd_pos_s, 5'b10000);
    chk("o_rd0_neg", rd_neg_s, 5'b00001);

    // Odd word count
    word(5'b11100);
    word(5'b00000);
    word(5'b01000);
    chk("odd_pre", odd_error, 0);
    end_stream();
    chk("odd_count", clause_count, 1);
    chk("odd_flag", odd_error, 1);
    chk("odd_ready", ready, 1);
    chk("odd_overflow", overflow, 0);
    read_chk("odd_rd0", 0, 5'b11100, 5'b00000);
    read_chk("odd_rd1", 1, 5'b00000, 5'b00000);

    // Reset mid-stream after the 5th word, with load still high
    word(5'b11100);
    word(5'b00000);
    word(5'b00011);
    word(5'b00100);
    word(5'b01000);
    reset = 1'b1;
    load  = 1'b1;
    i     = 5'b10101;
    cyc();
    chk("r_count", clause_count, 0);
    chk("r_odd", odd_error, 0);
    chk("r_ready", ready, 0);
    reset = 1'b0;
    pair(5'b00110, 5'b00001);
    pair(5'b10000, 5'b01000);
    end_stream();
    chk("r2_count", clause_count, 2);
    chk("r2_ready", ready, 1);
    chk("r2_odd", odd_error, 0);
    chk("r2_overflow", overflow, 0);
    read_chk("r2_rd0", 0, 5'b00110, 5'b00001);
    read_chk("r2_rd1", 1, 5'b10000, 5'b01000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
